// File: rtl/reg_file_rename_if.sv
// rtl/reg_file_rename_if.sv - dispatch/commit bundle between dispatcher, ROB and the renaming register file
interface reg_file_rename_if #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
);
    logic             issue_en;
    logic [4:0]       issue_rd;
    logic [ROB_W-1:0] issue_rob_id;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  rs1_val;
    logic             rs1_busy;
    logic [ROB_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs2_val;
    logic             rs2_busy;
    logic [ROB_W-1:0] rs2_tag;
    logic             commit_en;
    logic [4:0]       commit_rd;
    logic [ROB_W-1:0] commit_rob_id;
    logic [XLEN-1:0]  commit_val;
    logic             clear;

    modport master (
        output issue_en, issue_rd, issue_rob_id, rs1, rs2,
        output commit_en, commit_rd, commit_rob_id, commit_val, clear,
        input  rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag
    );

    modport slave (
        input  issue_en, issue_rd, issue_rob_id, rs1, rs2,
        input  commit_en, commit_rd, commit_rob_id, commit_val, clear,
        output rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag
    );
endinterface

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register ROB rename tags
// Optional same-cycle commit forwarding on reads: RF_COMMIT_BYPASS_EN.
module reg_file_rename #(
    parameter int REG_NUM = 32,
    parameter int ROB_W   = 4,
    parameter int XLEN    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    reg_file_rename_if.slave    bus
);
    logic [XLEN-1:0]  val_q  [REG_NUM];
    logic [ROB_W-1:0] tag_q  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic [4:0]       rs_idx  [2];
    logic [XLEN-1:0]  rd_val  [2];
    logic             rd_busy [2];
    logic [ROB_W-1:0] rd_tag  [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            if (bus.commit_en && bus.commit_rd != 5'd0) begin
                val_q[bus.commit_rd] <= bus.commit_val;
                // A commit from an older rename must not release a newer one
                if (busy_q[bus.commit_rd] && tag_q[bus.commit_rd] == bus.commit_rob_id)
                    busy_q[bus.commit_rd] <= 1'b0;
            end
            if (bus.clear) begin
                busy_q <= '0;
            end else if (bus.issue_en && bus.issue_rd != 5'd0) begin
                busy_q[bus.issue_rd] <= 1'b1;
                tag_q[bus.issue_rd]  <= bus.issue_rob_id;
            end
        end
    end

    assign rs_idx[0] = bus.rs1;
    assign rs_idx[1] = bus.rs2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p]  = '0;
            rd_busy[p] = 1'b0;
            rd_tag[p]  = '0;
            if (rs_idx[p] != 5'd0) begin
                rd_val[p]  = val_q[rs_idx[p]];
                rd_busy[p] = busy_q[rs_idx[p]];
                rd_tag[p]  = tag_q[rs_idx[p]];
`ifdef RF_COMMIT_BYPASS_EN
                if (rdy && bus.commit_en && bus.commit_rd == rs_idx[p] &&
                    busy_q[rs_idx[p]] && tag_q[rs_idx[p]] == bus.commit_rob_id) begin
                    rd_busy[p] = 1'b0;
                    rd_val[p]  = bus.commit_val;
                end
`endif
            end
        end
    end

    assign bus.rs1_val  = rd_val[0];
    assign bus.rs1_busy = rd_busy[0];
    assign bus.rs1_tag  = rd_tag[0];
    assign bus.rs2_val  = rd_val[1];
    assign bus.rs2_busy = rd_busy[1];
    assign bus.rs2_tag  = rd_tag[1];
endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - directed vector bench for reg_file_rename
module tb_reg_file_rename;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_rename_if #(.ROB_W(4), .XLEN(32)) bus ();

    reg_file_rename #(.REG_NUM(32), .ROB_W(4), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    typedef struct {
        logic        ie;  logic [4:0] ird; logic [3:0] iid;
        logic        ce;  logic [4:0] crd; logic [3:0] cid; logic [31:0] cv;
        logic        clr; logic [4:0] r1;  logic [4:0] r2;
        logic        b1;  logic [3:0] t1;  logic [31:0] v1;
        logic        b2;  logic [3:0] t2;  logic [31:0] v2;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.issue_en      = v.ie;
        bus.issue_rd      = v.ird;
        bus.issue_rob_id  = v.iid;
        bus.commit_en     = v.ce;
        bus.commit_rd     = v.crd;
        bus.commit_rob_id = v.cid;
        bus.commit_val    = v.cv;
        bus.clear         = v.clr;
        bus.rs1           = v.r1;
        bus.rs2           = v.r2;
    endtask

    task automatic idle();
        bus.issue_en = 1'b0; bus.issue_rd = '0; bus.issue_rob_id = '0;
        bus.commit_en = 1'b0; bus.commit_rd = '0; bus.commit_rob_id = '0;
        bus.commit_val = '0; bus.clear = 1'b0;
    endtask

    initial begin
        //        ie ird iid  ce crd cid cv            clr r1  r2  b1 t1  v1            b2 t2  v2
        vt[0]  = '{0, 0, 0,   0, 0, 0, 32'h0,        0,  5,  0,  0, 0,  32'h0,        0, 0,  32'h0};
        vt[1]  = '{1, 3, 7,   0, 0, 0, 32'h0,        0,  3,  3,  0, 0,  32'h0,        0, 0,  32'h0};
        vt[2]  = '{0, 0, 0,   0, 0, 0, 32'h0,        0,  3,  0,  1, 7,  32'h0,        0, 0,  32'h0};
        vt[3]  = '{0, 0, 0,   1, 3, 7, 32'hDEADBEEF, 0,  4,  0,  0, 0,  32'h0,        0, 0,  32'h0};
        vt[4]  = '{1, 4, 2,   0, 0, 0, 32'h0,        0,  3,  3,  0, 7,  32'hDEADBEEF, 0, 7,  32'hDEADBEEF};
        vt[5]  = '{1, 4, 9,   0, 0, 0, 32'h0,        0,  4,  0,  1, 2,  32'h0,        0, 0,  32'h0};
        vt[6]  = '{0, 0, 0,   1, 4, 2, 32'h11,       0,  4,  3,  1, 9,  32'h0,        0, 7,  32'hDEADBEEF};
        vt[7]  = '{1, 6, 1,   0, 0, 0, 32'h0,        0,  4,  0,  1, 9,  32'h11,       0, 0,  32'h0};
        vt[8]  = '{0, 0, 0,   1, 4, 9, 32'h22,       0,  6,  0,  1, 1,  32'h0,        0, 0,  32'h0};
        vt[9]  = '{1, 6, 5,   1, 6, 1, 32'h66,       0,  4,  0,  0, 9,  32'h22,       0, 0,  32'h0};
        vt[10] = '{1, 1, 10,  0, 0, 0, 32'h0,        0,  6,  0,  1, 5,  32'h66,       0, 0,  32'h0};
        vt[11] = '{1, 2, 11,  0, 0, 0, 32'h0,        0,  1,  0,  1, 10, 32'h0,        0, 0,  32'h0};
        vt[12] = '{1, 8, 12,  0, 0, 0, 32'h0,        0,  2,  0,  1, 11, 32'h0,        0, 0,  32'h0};
        vt[13] = '{1, 10, 3,  0, 0, 0, 32'h0,        1,  8,  10, 1, 12, 32'h0,        0, 0,  32'h0};
        vt[14] = '{0, 0, 0,   0, 0, 0, 32'h0,        0,  1,  10, 0, 10, 32'h0,        0, 0,  32'h0};
        vt[15] = '{1, 0, 6,   0, 0, 0, 32'h0,        0,  2,  8,  0, 11, 32'h0,        0, 12, 32'h0};
        vt[16] = '{0, 0, 0,   1, 0, 0, 32'hFFFF,     0,  0,  6,  0, 0,  32'h0,        0, 5,  32'h66};
        vt[17] = '{0, 0, 0,   1, 5, 0, 32'h77,       1,  0,  0,  0, 0,  32'h0,        0, 0,  32'h0};
        vt[18] = '{0, 0, 0,   0, 0, 0, 32'h0,        0,  5,  0,  0, 0,  32'h77,       0, 0,  32'h0};

        rst = 1'b1;
        rdy = 1'b1;
        idle();
        bus.rs1 = '0;
        bus.rs2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reads are checked before the edge, so each vector sees the state left by the previous ones
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d rs1_busy", i), {31'b0, bus.rs1_busy}, {31'b0, vt[i].b1});
            chk($sformatf("v%0d rs1_tag", i),  {28'b0, bus.rs1_tag},  {28'b0, vt[i].t1});
            chk($sformatf("v%0d rs1_val", i),  bus.rs1_val,           vt[i].v1);
            chk($sformatf("v%0d rs2_busy", i), {31'b0, bus.rs2_busy}, {31'b0, vt[i].b2});
            chk($sformatf("v%0d rs2_tag", i),  {28'b0, bus.rs2_tag},  {28'b0, vt[i].t2});
            chk($sformatf("v%0d rs2_val", i),  bus.rs2_val,           vt[i].v2);
        end

        // rdy low freezes both issue and commit
        @(negedge clk);
        idle();
        rdy = 1'b0;
        bus.issue_en = 1'b1; bus.issue_rd = 5'd9; bus.issue_rob_id = 4'd1;
        bus.commit_en = 1'b1; bus.commit_rd = 5'd9; bus.commit_val = 32'h99;
        @(negedge clk);
        idle();
        rdy = 1'b1;
        bus.rs1 = 5'd9;
        #1;
        chk("frozen busy", {31'b0, bus.rs1_busy}, 32'd0);
        chk("frozen val", bus.rs1_val, 32'h0);

        // Commit forwarding in the retiring cycle
        @(negedge clk);
        bus.issue_en = 1'b1; bus.issue_rd = 5'd7; bus.issue_rob_id = 4'd4;
        @(negedge clk);
        idle();
        bus.commit_en = 1'b1; bus.commit_rd = 5'd7; bus.commit_rob_id = 4'd4;
        bus.commit_val = 32'h55;
        bus.rs2 = 5'd7;
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        chk("bypass busy", {31'b0, bus.rs2_busy}, 32'd0);
        chk("bypass val", bus.rs2_val, 32'h55);
`else
        chk("nobypass busy", {31'b0, bus.rs2_busy}, 32'd1);
        chk("nobypass tag", {28'b0, bus.rs2_tag}, 32'd4);
`endif
        @(negedge clk);
        idle();
        #1;
        chk("post commit busy", {31'b0, bus.rs2_busy}, 32'd0);
        chk("post commit val", bus.rs2_val, 32'h55);

        // Reset mid-run returns every register to zero
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd3;
        #1;
        chk("rst rs1_val", bus.rs1_val, 32'h0);
        chk("rst rs2_val", bus.rs2_val, 32'h0);
        chk("rst rs2_tag", {28'b0, bus.rs2_tag}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
